// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package instr_fetch_queue_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned IFQ_DEPTH    = 4;
    localparam logic [31:0] IFQ_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INC       = 32'd4;

    typedef logic [XLEN-1:0] word_t;

    // One queue entry: instruction word plus the address it was fetched from.
    typedef struct packed {
        word_t ins;
        word_t pc;
    } fetch_entry_t;

    // Fetch addresses are always word aligned.
    function automatic word_t word_align(input word_t a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_queue_fetch_fifo.sv
// DEPTH x 64-bit ring buffer holding fetched {instruction, pc} pairs.
module fetch_fifo
    import instr_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IFQ_DEPTH
) (
    input  logic                       CLK,
    input  logic                       RSTn,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               wdata,
    output fetch_entry_t               rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr];

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PW'(1);
            if (do_pop)  rptr <= rptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only observed through occupied slots.
    always_ff @(posedge CLK) begin
        if (do_push && !flush) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: credit-based request issue, one-cycle memory
// response capture and a small queue feeding the decoder.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = IFQ_DEPTH,
    parameter logic [31:0] RESET_PC = IFQ_RESET_PC
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        redirect,
    input  logic [31:0] redirectPC,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic [31:0] imemRdata,
    output logic        insValid,
    input  logic        insReady,
    output logic [31:0] ins,
    output logic [31:0] insPC,
    output logic [31:0] insPCPlus4
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    word_t         fpc;
    word_t         tag;
    logic          inflight;
    logic          kill;
    logic [CW-1:0] count;
    logic [CW:0]   occ;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    // Credit counts both queued entries and the response still on its way;
    // RSTn gating keeps the request low while reset is asserted.
    assign occ      = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign imemReq  = RSTn & ~redirect & ~full & (occ < (CW+1)'(DEPTH));
    assign imemAddr = fpc;

    // A response arriving during a redirect belongs to the old stream and is dropped.
    assign push       = inflight & ~kill & ~redirect;
    assign pop        = insValid & insReady;
    assign push_entry = '{ins: imemRdata, pc: tag};

    assign insValid   = ~empty;
    assign ins        = insValid ? head.ins : '0;
    assign insPC      = insValid ? head.pc  : '0;
    assign insPCPlus4 = insPC + PC_INC;

    // Fetch PC, response tag and in-flight tracking.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            fpc      <= word_align(RESET_PC);
            tag      <= '0;
            inflight <= 1'b0;
            kill     <= 1'b0;
        end else begin
            inflight <= imemReq;
            // kill marks the response slot right after a redirect as stale
            kill     <= redirect;
            if (imemReq) tag <= fpc;
            if (redirect) begin
                fpc <= word_align(redirectPC);
            end else if (imemReq) begin
                fpc <= fpc + PC_INC;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata (push_entry),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue with a queue-based reference model.
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        CLK;
    logic        RSTn;
    logic        redirect;
    logic [31:0] redirectPC;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] imemRdata;
    logic        insValid;
    logic        insReady;
    logic [31:0] ins;
    logic [31:0] insPC;
    logic [31:0] insPCPlus4;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    // Reference model: delivered instructions in order, plus the fetch stream state.
    ent_t        mq[$];
    logic [31:0] m_fpc;
    logic [31:0] m_tag;
    bit          m_infl;
    logic [31:0] salt;

    instr_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .redirect   (redirect),
        .redirectPC (redirectPC),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemRdata  (imemRdata),
        .insValid   (insValid),
        .insReady   (insReady),
        .ins        (ins),
        .insPC      (insPC),
        .insPCPlus4 (insPCPlus4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got=running exp=finished");
        $fatal(1, "watchdog");
    end

    function automatic bit m_req();
        return (RSTn === 1'b1) && (redirect !== 1'b1) && ((mq.size() + int'(m_infl)) < DEPTH);
    endfunction

    function automatic bit m_valid();
        return (RSTn === 1'b1) && (mq.size() > 0);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_infl = 0;
        m_tag  = '0;
        m_fpc  = RESET_PC;
    endtask

    // Advance one clock: update the model, then serve the memory response.
    task automatic tick();
        bit          req_m;
        bit          pop_m;
        logic        dreq;
        logic [31:0] daddr;
        req_m = m_req();
        pop_m = m_valid() && (insReady === 1'b1);
        dreq  = imemReq;
        daddr = imemAddr;
        @(posedge CLK);
        if (redirect) begin
            mq.delete();
            m_infl = 0;
            m_fpc  = {redirectPC[31:2], 2'b00};
        end else begin
            if (pop_m) void'(mq.pop_front());
            if (m_infl) mq.push_back('{pc: m_tag, ins: m_tag + salt});
            m_infl = req_m;
            if (req_m) begin
                m_tag = m_fpc;
                m_fpc = m_fpc + 32'd4;
            end
        end
        #1;
        imemRdata = dreq ? daddr + salt : $urandom;
    endtask

    task automatic do_reset(input logic [31:0] s);
        RSTn     = 1'b0;
        redirect = 1'b0;
        insReady = 1'b0;
        model_reset();
        salt = s;
        @(posedge CLK);
        #1;
        RSTn      = 1'b1;
        imemRdata = $urandom;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (imemReq !== 1'b0)      begin errors++; $display("FAIL rst_req got=%b exp=0", imemReq); end
        checks++; if (insValid !== 1'b0)     begin errors++; $display("FAIL rst_valid got=%b exp=0", insValid); end
        checks++; if (ins !== 32'h0)         begin errors++; $display("FAIL rst_ins got=%h exp=0", ins); end
        checks++; if (insPC !== 32'h0)       begin errors++; $display("FAIL rst_pc got=%h exp=0", insPC); end
        checks++; if (insPCPlus4 !== 32'h4)  begin errors++; $display("FAIL rst_pc4 got=%h exp=4", insPCPlus4); end
        checks++; if (imemAddr !== RESET_PC) begin errors++; $display("FAIL rst_addr got=%h exp=%h", imemAddr, RESET_PC); end
        do_reset(32'h2000_0000);
    endtask

    task automatic test_fetch_order();
        do_reset(32'h2000_0000);
        insReady = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++; if (imemReq !== 1'b1) begin errors++; $display("FAIL order_req k=%0d got=%b exp=1", k, imemReq); end
            checks++; if (imemAddr !== 32'(4*k)) begin errors++; $display("FAIL order_addr k=%0d got=%h exp=%h", k, imemAddr, 32'(4*k)); end
            checks++; if (insValid !== (k >= 2)) begin errors++; $display("FAIL order_valid k=%0d got=%b exp=%b", k, insValid, k >= 2); end
            if (k >= 2) begin
                checks++; if (insPC !== 32'(4*(k-2))) begin errors++; $display("FAIL order_pc k=%0d got=%h exp=%h", k, insPC, 32'(4*(k-2))); end
                checks++; if (ins !== 32'(4*(k-2)) + 32'h2000_0000) begin errors++; $display("FAIL order_ins k=%0d got=%h exp=%h", k, ins, 32'(4*(k-2)) + 32'h2000_0000); end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        do_reset(32'h2000_0000);
        insReady = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++; if (imemReq !== (k < 4)) begin errors++; $display("FAIL stall_req k=%0d got=%b exp=%b", k, imemReq, k < 4); end
            if (k < 4) begin
                checks++; if (imemAddr !== 32'(4*k)) begin errors++; $display("FAIL stall_addr k=%0d got=%h exp=%h", k, imemAddr, 32'(4*k)); end
            end
            checks++; if (insValid !== (k >= 2)) begin errors++; $display("FAIL stall_valid k=%0d got=%b exp=%b", k, insValid, k >= 2); end
            if (k >= 2) begin
                checks++; if (insPC !== 32'h0) begin errors++; $display("FAIL stall_pc k=%0d got=%h exp=0", k, insPC); end
                checks++; if (ins !== 32'h2000_0000) begin errors++; $display("FAIL stall_ins k=%0d got=%h exp=20000000", k, ins); end
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        do_reset($urandom);
        insReady = 1'b1;
        for (int k = 0; k < 4; k++) begin #1; tick(); end
        // first redirect with a response in flight and a pop handshake this cycle
        redirect = 1'b1; redirectPC = 32'h0030_0000;
        #1;
        checks++; if (imemReq !== 1'b0)  begin errors++; $display("FAIL redir1_req got=%b exp=0", imemReq); end
        checks++; if (insValid !== 1'b1) begin errors++; $display("FAIL redir1_valid got=%b exp=1", insValid); end
        tick();
        redirectPC = 32'h0040_002A;
        #1;
        checks++; if (imemReq !== 1'b0)  begin errors++; $display("FAIL redir2_req got=%b exp=0", imemReq); end
        checks++; if (insValid !== 1'b0) begin errors++; $display("FAIL redir2_valid got=%b exp=0", insValid); end
        tick();
        redirect = 1'b0;
        #1;
        checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h0040_0028) begin errors++; $display("FAIL redir_addr0 got=%b/%h exp=1/00400028", imemReq, imemAddr); end
        checks++; if (insValid !== 1'b0) begin errors++; $display("FAIL redir_nobypass0 got=%b exp=0", insValid); end
        tick();
        #1;
        checks++; if (imemAddr !== 32'h0040_002C) begin errors++; $display("FAIL redir_addr1 got=%h exp=0040002c", imemAddr); end
        checks++; if (insValid !== 1'b0) begin errors++; $display("FAIL redir_nobypass1 got=%b exp=0", insValid); end
        tick();
        #1;
        checks++; if (insValid !== 1'b1 || insPC !== 32'h0040_0028) begin errors++; $display("FAIL redir_head got=%b/%h exp=1/00400028", insValid, insPC); end
        checks++; if (insPCPlus4 !== 32'h0040_002C) begin errors++; $display("FAIL redir_pc4 got=%h exp=0040002c", insPCPlus4); end
        checks++; if (ins !== 32'h0040_0028 + salt) begin errors++; $display("FAIL redir_ins got=%h exp=%h", ins, 32'h0040_0028 + salt); end
        tick();
        #1;
        checks++; if (insPC !== 32'h0040_002C) begin errors++; $display("FAIL redir_next got=%h exp=0040002c", insPC); end
        tick();
    endtask

    task automatic test_wrap_pops();
        do_reset($urandom);
        insReady = 1'b0;
        for (int k = 0; k < 3; k++) begin #1; tick(); end
        // now two entries queued and one response in flight
        insReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++; if (insValid !== 1'b1) begin errors++; $display("FAIL wrap_valid i=%0d got=%b exp=1", i, insValid); end
            checks++; if (insPC !== 32'(4*i)) begin errors++; $display("FAIL wrap_pc i=%0d got=%h exp=%h", i, insPC, 32'(4*i)); end
            tick();
        end
    endtask

    task automatic test_pc_wrap();
        do_reset($urandom);
        insReady   = 1'b1;
        redirect   = 1'b1;
        redirectPC = 32'hFFFF_FFFE;
        #1; tick();
        redirect = 1'b0;
        #1;
        checks++; if (imemAddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL pcwrap_addr0 got=%h exp=fffffffc", imemAddr); end
        tick();
        #1;
        checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin errors++; $display("FAIL pcwrap_addr1 got=%b/%h exp=1/0", imemReq, imemAddr); end
        tick();
        #1;
        checks++; if (insPC !== 32'hFFFF_FFFC || insPCPlus4 !== 32'h0) begin errors++; $display("FAIL pcwrap_head got=%h/%h exp=fffffffc/0", insPC, insPCPlus4); end
        tick();
        #1;
        checks++; if (insPC !== 32'h0 || insPCPlus4 !== 32'h4) begin errors++; $display("FAIL pcwrap_next got=%h/%h exp=0/4", insPC, insPCPlus4); end
        tick();
    endtask

    task automatic test_async_reset();
        do_reset($urandom);
        insReady = 1'b1;
        for (int k = 0; k < 5; k++) begin #1; tick(); end
        #1;
        RSTn = 1'b0;
        #1;
        checks++; if (insValid !== 1'b0 || imemReq !== 1'b0) begin errors++; $display("FAIL arst_outs got=%b/%b exp=0/0", insValid, imemReq); end
        checks++; if (insPC !== 32'h0) begin errors++; $display("FAIL arst_pc got=%h exp=0", insPC); end
        model_reset();
        #1;
        RSTn = 1'b1;
        #1;
        checks++; if (imemReq !== 1'b1 || imemAddr !== RESET_PC) begin errors++; $display("FAIL arst_restart got=%b/%h exp=1/%h", imemReq, imemAddr, RESET_PC); end
        tick();
        #1; tick();
        #1;
        checks++; if (insValid !== 1'b1 || insPC !== RESET_PC) begin errors++; $display("FAIL arst_head got=%b/%h exp=1/%h", insValid, insPC, RESET_PC); end
        tick();
    endtask

    task automatic test_random();
        do_reset($urandom);
        for (int c = 0; c < 400; c++) begin
            insReady   = ($urandom_range(0, 9) < 7);
            redirect   = ($urandom_range(0, 19) == 0);
            redirectPC = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            #1;
            checks++; if (imemReq !== m_req()) begin errors++; $display("FAIL rnd_req c=%0d got=%b exp=%b", c, imemReq, m_req()); end
            if (m_req()) begin
                checks++; if (imemAddr !== m_fpc) begin errors++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, imemAddr, m_fpc); end
            end
            checks++; if (insValid !== m_valid()) begin errors++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, insValid, m_valid()); end
            if (m_valid()) begin
                checks++;
                if (insPC !== mq[0].pc || ins !== mq[0].ins || insPCPlus4 !== mq[0].pc + 32'd4) begin
                    errors++;
                    $display("FAIL rnd_head c=%0d got=%h/%h/%h exp=%h/%h/%h", c, insPC, ins, insPCPlus4, mq[0].pc, mq[0].ins, mq[0].pc + 32'd4);
                end
            end
            tick();
        end
        redirect = 1'b0;
    endtask

    initial begin
        RSTn       = 1'b0;
        redirect   = 1'b0;
        redirectPC = '0;
        insReady   = 1'b0;
        imemRdata  = '0;
        salt       = '0;
        model_reset();
        test_reset();
        test_fetch_order();
        test_stall();
        test_redirect();
        test_wrap_pops();
        test_pc_wrap();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 32'h00000000, fetch address after reset.
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RSTn  input  1  reset, asynchronous, active-low.
REQ-005 redirect  input  1  PC-control redirect (taken branch, jump, jr).
REQ-006 redirectPC  input  32  new fetch address, valid when redirect=1.
REQ-007 imemReq  output  1  instruction-memory read request.
REQ-008 imemAddr  output  32  word address of the request.
REQ-009 imemRdata  input  32  read data, valid exactly one cycle after imemReq.
REQ-010 insValid  output  1  queue head holds a valid instruction.
REQ-011 insReady  input  1  decoder accepts the head this cycle.
REQ-012 ins  output  32  head instruction word.
REQ-013 insPC  output  32  address of the head instruction.
REQ-014 insPCPlus4  output  32  insPC + 4, modulo 2^32.

Function
REQ-015 Fetch PC register fpc drives imemAddr; fpc[1:0] is always 2'b00.
REQ-016 imemReq = 1 iff redirect=0 and (count + inflight) < DEPTH, using registered count and inflight; a pop in the same cycle grants no credit.
REQ-017 On each cycle with imemReq=1, fpc advances by 4 (wrap 32'hFFFFFFFC -> 0).
REQ-018 inflight register = imemReq of the previous cycle, with its address in a 32-bit tag register.
REQ-019 When inflight=1 and not killed, {imemRdata, tag} is pushed into the queue at that cycle's edge.
REQ-020 Latency: request in cycle n -> insValid earliest in cycle n+2; no bypass of an empty queue.
REQ-021 Throughput with insReady held 1: one instruction per cycle in steady state.
REQ-022 Pop occurs on insValid=1 and insReady=1; ins/insPC stay stable while insValid=1 and insReady=0.
REQ-023 Simultaneous push and pop: occupancy unchanged, order preserved.
REQ-024 Queue is a ring buffer; read/write pointers wrap modulo DEPTH; push never occurs when full (guaranteed by REQ-016).
REQ-025 redirect=1: at that edge queue emptied, in-flight response killed, fpc <= {redirectPC[31:2], 2'b00}; imemReq = 0 during the redirect cycle.
REQ-026 redirect with simultaneous pop: the pop completes (handshake counted), then flush applies.
REQ-027 Back-to-back redirects: last one wins; no instruction from an earlier target is delivered.
REQ-028 First request after redirect issues in the following cycle at the new fpc.

Reset
REQ-029 RSTn=0 asynchronously: fpc=RESET_PC, count=0, pointers=0, inflight=0, kill=0.
REQ-030 Outputs during reset: imemReq=0, insValid=0, ins/insPC=0, insPCPlus4=4.
REQ-031 Reset mid-operation discards all queued and in-flight data; first request after RSTn rises is at RESET_PC.

Structure
REQ-032 Shared package holds DEPTH and RESET_PC defaults, word/address width (32) and PC increment (4).
REQ-033 One sub-module, fetch_fifo: DEPTH x 64-bit ring buffer with push, pop, flush, count, full, empty.
REQ-034 Fetch control (fpc, credit, inflight, kill) stays in the top module.

Verification
REQ-035 Reset release, insReady=1, imemRdata=addr+32'h20000000: imemAddr 0,4,8,12; insValid first 2 cycles after first imemReq; insPC 0,4,8 in order.
REQ-036 insReady=0 for 8 cycles: 4 entries fill, imemReq drops to 0, ins/insPC hold at head (insPC=0) throughout.
REQ-037 redirect=1, redirectPC=32'h0040002A with a request in flight: in-flight word dropped; next insPC=32'h00400028, insPCPlus4=32'h0040002C.
REQ-038 Occupancy 2, push and pop same cycle: count stays 2; 10 sequential pops deliver insPC strictly +4, crossing pointer wrap.
REQ-039 RSTn pulsed low asynchronously mid-stream (between edges): insValid and imemReq 0 immediately; restart at RESET_PC.
REQ-040 fpc=32'hFFFFFFFC, insReady=1: next imemAddr 0; delivered insPCPlus4 for that head is 0.
